// File: rtl/maze_world_model_if.sv
// Explorer <-> maze world bus: configuration, move commands and the
// sensor/status view of the bot.
interface maze_world_model_if #(
  parameter int ADDR_W = 7
);
  logic              run;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [3:0]        cfg_data;
  logic [2:0]        move;
  logic              left;
  logic              mid;
  logic              right;
  logic [3:0]        pos_row;
  logic [3:0]        pos_col;
  logic [1:0]        heading;
  logic              done;
  logic              illegal;
  logic [15:0]       step_cnt;
  logic [7:0]        deadend_cnt;

  modport master (
    output run, cfg_we, cfg_addr, cfg_data, move,
    input  left, mid, right, pos_row, pos_col, heading,
           done, illegal, step_cnt, deadend_cnt
  );

  modport slave (
    input  run, cfg_we, cfg_addr, cfg_data, move,
    output left, mid, right, pos_row, pos_col, heading,
           done, illegal, step_cnt, deadend_cnt
  );
endinterface

// File: rtl/maze_world_model.sv
// Maze environment: holds the wall map and the bot's pose, applies the
// explorer's move commands and reports wall sensing plus statistics.
module maze_world_model #(
  parameter int ROWS       = 9,
  parameter int COLS       = 9,
  parameter int ADDR_W     = 7,
  parameter int START_ROW  = 4,
  parameter int START_COL  = 0,
  parameter int START_HEAD = 1,
  parameter int EXIT_ROW   = 4,
  parameter int EXIT_COL   = 8
) (
  input logic             clk,
  input logic             rst_n,
  maze_world_model_if.slave bus
);

  localparam int CELLS = ROWS * COLS;

  logic [3:0]        map_mem [CELLS];
  logic [3:0]        row_q;
  logic [3:0]        col_q;
  logic [1:0]        head_q;
  logic              done_q;
  logic              illegal_q;
  logic [15:0]       step_q;
  logic [7:0]        dead_q;

  logic [ADDR_W-1:0] cur_idx;
  logic [ADDR_W-1:0] nxt_idx;
  logic [3:0]        cur_walls;
  logic [3:0]        nxt_walls;
  logic [3:0]        nxt_row;
  logic [3:0]        nxt_col;
  logic [1:0]        dir;
  logic [1:0]        left_dir;
  logic [1:0]        right_dir;
  logic              is_move;
  logic              bad_code;
  logic              nxt_dead;
  logic              nxt_exit;
  logic              cfg_ok;

  // Walls forced by the outer edge of the maze, bit order N,E,S,W.
  function automatic logic [3:0] edge_walls(input logic [3:0] r, input logic [3:0] c);
    logic [3:0] w;
    w    = '0;
    w[0] = (r == 4'd0);
    w[1] = (c == 4'(COLS - 1));
    w[2] = (r == 4'(ROWS - 1));
    w[3] = (c == 4'd0);
    return w;
  endfunction

  // Effective walls of the current cell and of the cell the move targets,
  // plus decoding of the move into an absolute direction.
  always_comb begin
    is_move  = 1'b0;
    bad_code = 1'b0;
    dir      = head_q;
    case (bus.move)
      3'd1: begin is_move = 1'b1; dir = head_q;         end
      3'd2: begin is_move = 1'b1; dir = head_q + 2'd3;  end
      3'd3: begin is_move = 1'b1; dir = head_q + 2'd1;  end
      3'd4: begin is_move = 1'b1; dir = head_q + 2'd2;  end
      3'd5, 3'd6, 3'd7: bad_code = 1'b1;
      default: ;
    endcase

    cur_idx   = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
    cur_walls = edge_walls(row_q, col_q);
    if (int'(cur_idx) < CELLS)
      cur_walls = cur_walls | map_mem[cur_idx];

    nxt_row = row_q;
    nxt_col = col_q;
    case (dir)
      2'd0: nxt_row = row_q - 4'd1;
      2'd1: nxt_col = col_q + 4'd1;
      2'd2: nxt_row = row_q + 4'd1;
      default: nxt_col = col_q - 4'd1;
    endcase

    nxt_idx   = ADDR_W'(nxt_row) * ADDR_W'(COLS) + ADDR_W'(nxt_col);
    nxt_walls = edge_walls(nxt_row, nxt_col);
    if (int'(nxt_idx) < CELLS)
      nxt_walls = nxt_walls | map_mem[nxt_idx];

    nxt_dead = ($countones(nxt_walls) == 3);
    nxt_exit = (nxt_row == 4'(EXIT_ROW)) && (nxt_col == 4'(EXIT_COL));
    cfg_ok   = (int'(bus.cfg_addr) < CELLS);

    left_dir  = head_q + 2'd3;
    right_dir = head_q + 2'd1;
  end

  // Map writes in configuration mode and pose/statistics updates in run mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) map_mem[i] <= '0;
      row_q     <= 4'(START_ROW);
      col_q     <= 4'(START_COL);
      head_q    <= 2'(START_HEAD);
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      step_q    <= '0;
      dead_q    <= '0;
    end else if (!bus.run) begin
      if (bus.cfg_we && cfg_ok)
        map_mem[bus.cfg_addr] <= bus.cfg_data;
    end else if (!done_q) begin
      if (bad_code) begin
        illegal_q <= 1'b1;
      end else if (is_move) begin
        if (cur_walls[dir]) begin
          illegal_q <= 1'b1;
        end else begin
          head_q <= dir;
          row_q  <= nxt_row;
          col_q  <= nxt_col;
          if (step_q != 16'hFFFF) step_q <= step_q + 16'd1;
          if (nxt_dead && dead_q != 8'hFF) dead_q <= dead_q + 8'd1;
          if (nxt_exit) done_q <= 1'b1;
        end
      end
    end
  end

  // Sensors and status straight from the registered state.
  always_comb begin
    bus.left        = cur_walls[left_dir];
    bus.mid         = cur_walls[head_q];
    bus.right       = cur_walls[right_dir];
    bus.pos_row     = row_q;
    bus.pos_col     = col_q;
    bus.heading     = head_q;
    bus.done        = done_q;
    bus.illegal     = illegal_q;
    bus.step_cnt    = step_q;
    bus.deadend_cnt = dead_q;
  end

endmodule

// File: tb/tb_maze_world_model.sv
// Scoreboard bench for maze_world_model: a grid-level reference model
// predicts the state after every clock, a monitor compares at negedge.
module tb_maze_world_model;

  localparam int ROWS   = 9;
  localparam int COLS   = 9;
  localparam int ADDR_W = 7;
  localparam int CELLS  = ROWS * COLS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  maze_world_model_if #(.ADDR_W(ADDR_W)) bus ();

  maze_world_model #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W),
    .START_ROW(4), .START_COL(0), .START_HEAD(1),
    .EXIT_ROW(4), .EXIT_COL(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int row, col, head, left, mid, right, done, ill, step, dead;
  } exp_t;

  exp_t exp_q[$];

  int m_map[CELLS];
  int m_row, m_col, m_head, m_done, m_ill, m_step, m_dead;

  int check_count = 0;
  int pass_count  = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Walls of a cell as the bot sees them: stored bits plus the outer edge.
  function automatic int eff(input int r, input int c);
    int w;
    w = m_map[r * COLS + c];
    if (r == 0)        w |= 1;
    if (c == COLS - 1) w |= 2;
    if (r == ROWS - 1) w |= 4;
    if (c == 0)        w |= 8;
    return w;
  endfunction

  function automatic void model_step(input bit rst, input bit run_i, input bit we,
                                     input int addr, input int data, input int mv);
    int d, w, nr, nc, cnt;
    if (!rst) begin
      foreach (m_map[i]) m_map[i] = 0;
      m_row = 4; m_col = 0; m_head = 1;
      m_done = 0; m_ill = 0; m_step = 0; m_dead = 0;
      return;
    end
    if (!run_i) begin
      if (we && addr < CELLS) m_map[addr] = data;
      return;
    end
    if (m_done) return;
    if (mv >= 5) begin
      m_ill = 1;
      return;
    end
    case (mv)
      1: d = m_head;
      2: d = (m_head + 3) % 4;
      3: d = (m_head + 1) % 4;
      4: d = (m_head + 2) % 4;
      default: return;
    endcase
    w = eff(m_row, m_col);
    if ((w >> d) & 1) begin
      m_ill = 1;
      return;
    end
    nr = m_row; nc = m_col;
    if (d == 0) nr--;
    if (d == 1) nc++;
    if (d == 2) nr++;
    if (d == 3) nc--;
    m_row = nr; m_col = nc; m_head = d;
    if (m_step < 65535) m_step++;
    w = eff(nr, nc);
    cnt = 0;
    for (int b = 0; b < 4; b++) cnt += (w >> b) & 1;
    if (cnt == 3 && m_dead < 255) m_dead++;
    if (nr == 4 && nc == 8) m_done = 1;
  endfunction

  task automatic apply_stimulus(input bit rst, input bit run_i, input bit we,
                                input int addr, input int data, input int mv);
    exp_t e;
    int w;
    rst_n        = rst;
    bus.run      = run_i;
    bus.cfg_we   = we;
    bus.cfg_addr = addr[ADDR_W-1:0];
    bus.cfg_data = data[3:0];
    bus.move     = mv[2:0];
    model_step(rst, run_i, we, addr, data, mv);
    w = eff(m_row, m_col);
    e.row   = m_row;  e.col  = m_col;  e.head = m_head;
    e.left  = (w >> ((m_head + 3) % 4)) & 1;
    e.mid   = (w >> m_head) & 1;
    e.right = (w >> ((m_head + 1) % 4)) & 1;
    e.done  = m_done; e.ill  = m_ill;
    e.step  = m_step; e.dead = m_dead;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: every output-bearing cycle is compared against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("pos_row",     int'(bus.pos_row),     e.row);
        check_output("pos_col",     int'(bus.pos_col),     e.col);
        check_output("heading",     int'(bus.heading),     e.head);
        check_output("left",        int'(bus.left),        e.left);
        check_output("mid",         int'(bus.mid),         e.mid);
        check_output("right",       int'(bus.right),       e.right);
        check_output("done",        int'(bus.done),        e.done);
        check_output("illegal",     int'(bus.illegal),     e.ill);
        check_output("step_cnt",    int'(bus.step_cnt),    e.step);
        check_output("deadend_cnt", int'(bus.deadend_cnt), e.dead);
      end
    end
  end

  task automatic do_reset();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int r, mv, data;

    // Plain forward step on an empty map.
    do_reset();
    apply_stimulus(1, 1, 0, 0, 0, 1);
    check_output("fwd_pos_col", int'(bus.pos_col), 1);
    check_output("fwd_step", int'(bus.step_cnt), 1);

    // Blocked by a wall in the start cell.
    do_reset();
    apply_stimulus(1, 0, 1, 4 * 9 + 0, 4'b1010, 0);
    apply_stimulus(1, 1, 0, 0, 0, 1);
    check_output("blk_pos_col", int'(bus.pos_col), 0);
    check_output("blk_illegal", int'(bus.illegal), 1);
    check_output("blk_mid", int'(bus.mid), 1);

    // Turns, then a dead end entered repeatedly until its counter saturates.
    do_reset();
    apply_stimulus(1, 0, 1, 3 * 9 + 1, 4'b1011, 0);
    apply_stimulus(1, 1, 0, 0, 0, 1);
    apply_stimulus(1, 1, 0, 0, 0, 2);
    check_output("de_pos_row", int'(bus.pos_row), 3);
    check_output("de_count", int'(bus.deadend_cnt), 1);
    for (int i = 0; i < 600; i++) apply_stimulus(1, 1, 0, 0, 0, 4);
    check_output("de_saturate", int'(bus.deadend_cnt), 255);

    // Straight run to the exit, extra move ignored.
    do_reset();
    for (int i = 0; i < 9; i++) apply_stimulus(1, 1, 0, 0, 0, 1);
    check_output("exit_col", int'(bus.pos_col), 8);
    check_output("exit_done", int'(bus.done), 1);
    check_output("exit_step", int'(bus.step_cnt), 8);

    // Unknown code, then reset in the middle of a run.
    do_reset();
    apply_stimulus(1, 1, 0, 0, 0, 6);
    check_output("bad_code_ill", int'(bus.illegal), 1);
    check_output("bad_code_step", int'(bus.step_cnt), 0);
    apply_stimulus(1, 1, 0, 0, 0, 1);
    apply_stimulus(0, 1, 0, 0, 0, 1);
    check_output("rst_pos_col", int'(bus.pos_col), 0);
    check_output("rst_illegal", int'(bus.illegal), 0);

    // Randomised traffic: config writes, ignored writes, moves, resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        apply_stimulus(0, $urandom_range(0, 1), 0, 0, 0, 0);
      end else if (r < 14) begin
        data = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1) << $urandom_range(0, 3);
        apply_stimulus(1, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 127), data, $urandom_range(0, 7));
      end else if (r < 18) begin
        apply_stimulus(1, 1, 1, $urandom_range(0, CELLS - 1), $urandom_range(0, 15), $urandom_range(0, 4));
      end else begin
        r = $urandom_range(0, 99);
        if (r < 50)      mv = 1;
        else if (r < 62) mv = 2;
        else if (r < 74) mv = 3;
        else if (r < 84) mv = 4;
        else if (r < 95) mv = 0;
        else             mv = $urandom_range(5, 7);
        apply_stimulus(1, 1, 0, 0, 0, mv);
      end
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) check_output("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/maze_world_model.md
Name: maze_world_model

Overview:
- Behavioural-synthesisable maze environment for closed-loop testing of the maze explorer. Consumes the explorer's 3-bit move command each cycle and returns left/mid/right wall sensing for the bot's current cell and heading.
- Holds a configurable ROWSxCOLS wall map, bot position and heading, exit detection, and step/dead-end/illegal-move statistics.
- Sits between the explorer and the testbench or top level.

Parameters:
- ROWS, 9, maze rows (row 0 = north edge).
- COLS, 9, maze columns (col 0 = west edge).
- ADDR_W, 7, cell address width; ROWS*COLS <= 2^ADDR_W.
- START_ROW, 4, reset row.
- START_COL, 0, reset column.
- START_HEAD, 1, reset heading (0=N, 1=E, 2=S, 3=W).
- EXIT_ROW, 4, exit cell row.
- EXIT_COL, 8, exit cell column.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  1 = consume move each cycle; 0 = configuration mode.
- cfg_we  in  1  map write strobe; honoured only when run=0.
- cfg_addr  in  ADDR_W  cell index = row*COLS+col.
- cfg_data  in  4  walls of cell: [0]=N, [1]=E, [2]=S, [3]=W; 1 = wall.
- move  in  3  0 STOP, 1 FORWARD, 2 LEFT, 3 RIGHT, 4 U_TURN.
- left, mid, right  out  1 each  wall on bot's left/ahead/right in current cell.
- pos_row  out  4  current row.
- pos_col  out  4  current column.
- heading  out  2  current heading.
- done  out  1  sticky; bot has entered the exit cell.
- illegal  out  1  sticky; an illegal move was seen.
- step_cnt  out  16  accepted moves, saturating at 0xFFFF.
- deadend_cnt  out  8  entries into cells with exactly 3 walls, saturating at 0xFF.

Behaviour:
- Reset (rst_n=0 at posedge):
  - All map cells cleared to 0.
  - pos = (START_ROW, START_COL), heading = START_HEAD.
  - done = 0, illegal = 0, step_cnt = 0, deadend_cnt = 0.
  - Reset mid-run discards all state, including the map.
- Effective walls: the stored cell bits OR'd with forced boundary walls (N at row 0, S at row ROWS-1, W at col 0, E at col COLS-1). Only the current cell's bits are used; neighbour consistency is not checked.
- Sensors are combinational from registered pos/heading/map.
  - left = wall[(h+3)%4], mid = wall[h], right = wall[(h+1)%4].
  - They reflect the new cell in the same cycle the new position appears.
- Configuration:
  - When run=0 and cfg_we=1, map[cfg_addr] <= cfg_data at posedge.
  - Writes with cfg_addr >= ROWS*COLS are dropped.
  - cfg_we while run=1 is ignored.
- Move handling: move is sampled at every posedge with run=1, done=0, and rst_n=1. Target direction d:
  - FORWARD: d = h.
  - LEFT: d = (h+3)%4.
  - RIGHT: d = (h+1)%4.
  - U_TURN: d = (h+2)%4.
  - STOP: no change, no count.
  - Codes 5-7: treated as STOP, and illegal <= 1.
- Legal move (effective wall[d] = 0):
  - heading <= d, and pos steps one cell toward d (N: row-1, E: col+1, S: row+1, W: col-1).
  - step_cnt increments.
  - If the new cell's effective wall popcount is 3, deadend_cnt increments.
  - If the new cell is (EXIT_ROW, EXIT_COL), done <= 1.
- Blocked move (wall[d] = 1): pos and heading unchanged, illegal <= 1, step_cnt unchanged.
- Latency: one cycle from sampled move to updated pos/heading/sensors/counters.
- Freeze conditions:
  - After done=1, moves are ignored (state frozen) until reset.
  - With run=0, pos and heading are held.
- Start cell is not counted as a dead end at reset. Re-entering a dead-end cell counts again.
- Simultaneous events: an exit-cell entry that is also a dead end increments deadend_cnt and sets done in the same cycle.

Test Plan:
- Reset, run=1, move=1 with an empty map: pos goes (4,0)->(4,1) after 1 cycle, heading=1, step_cnt=1, left=mid=right=0 (no boundary at row 4 mid-maze).
- Boundary: write map[4*9+0]=4'b1010 (E and W walls), run=1, move=1: blocked, pos stays (4,0), illegal=1, step_cnt=0, mid=1.
- Turn semantics: heading E at (4,1), move=2 (LEFT): pos (3,1), heading=0. Then move=4 (U_TURN): pos (4,1), heading=2.
- Dead end: map[3*9+1]=4'b1011 (N, E, W walls), from (4,1) heading E issue LEFT: pos (3,1), deadend_cnt=1, left=1, mid=1, right=1.
- Exit: open corridor along row 4, 8 FORWARDs from reset: done=1 at pos (4,8), step_cnt=8. A further move=1 leaves pos unchanged.
- Invalid/reset: move=6 sets illegal with no motion and step_cnt unchanged. Asserting rst_n=0 mid-run restores (4,0), heading=1, all counters and flags 0, map cleared.
